// File: rtl/chip_top_wrapper.sv
// Pad and reset wrapper between board pins and the mmRISC SoC: power-on/system reset,
// boot-strap latching, JTAG/cJTAG routing and tri-state/open-drain pad control.
module chip_top_wrapper #(
  parameter int unsigned POR_CYCLES = 16,
  parameter int unsigned GPIO_W     = 32
) (
  input  logic              CLK50,
  input  logic              RES_N,
  output logic              RESOUT_N,
  inout  wire               SRSTn,
  input  logic              core_srst_req,
  output logic              STBY_ACK_N,
  input  logic              core_stby_ack,
  output logic [4:0]        strap_o,
  input  logic              TRSTn,
  input  logic              TCK,
  input  logic              TMS,
  input  logic              TDI,
  output wire               TDO,
  inout  wire               TCKC_pri,
  inout  wire               TMSC_pri,
  output wire               TMSC_PUP_rep,
  output wire               TMSC_PDN_rep,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  output logic              jtag_trst_n,
  input  logic              core_tdo,
  input  logic              core_tdo_oe,
  input  logic              core_tmsc_o,
  input  logic              core_tmsc_oe,
  input  logic              core_pup,
  input  logic              core_pdn,
  inout  wire  [GPIO_W-1:0] GPIO0,
  inout  wire  [GPIO_W-1:0] GPIO1,
  inout  wire  [GPIO_W-1:0] GPIO2,
  input  logic [GPIO_W-1:0] gpio0_o,
  input  logic [GPIO_W-1:0] gpio0_oe,
  output logic [GPIO_W-1:0] gpio0_i,
  input  logic [GPIO_W-1:0] gpio1_o,
  input  logic [GPIO_W-1:0] gpio1_oe,
  output logic [GPIO_W-1:0] gpio1_i,
  input  logic [GPIO_W-1:0] gpio2_o,
  input  logic [GPIO_W-1:0] gpio2_oe,
  output logic [GPIO_W-1:0] gpio2_i,
  inout  wire               I2C0_SCL,
  inout  wire               I2C0_SDA,
  inout  wire               I2C1_SCL,
  inout  wire               I2C1_SDA,
  input  logic              i2c0_scl_oe,
  input  logic              i2c0_sda_oe,
  input  logic              i2c1_scl_oe,
  input  logic              i2c1_sda_oe,
  output logic              i2c0_scl_i,
  output logic              i2c0_sda_i,
  output logic              i2c1_scl_i,
  output logic              i2c1_sda_i,
  output logic              I2C0_ENA,
  output logic              I2C0_ADR
);

  localparam logic [7:0] POR_LAST = 8'(POR_CYCLES);

  logic [7:0] por_count;
  logic       por_n;
  logic [1:0] srst_sync;
  logic       rst_req;
  logic       srst_drive;
  logic       enable_cjtag;
  logic       unused_strap_drive;

  assign rst_req      = !por_n || !srst_sync[1];
  assign srst_drive   = core_srst_req || (!RESOUT_N && !por_n);
  assign enable_cjtag = strap_o[0];

  // The POR counter is only cleared by RES_N; an SRSTn request reuses the sync path alone.
  always_ff @(posedge CLK50) begin
    if (!RES_N) begin
      por_count <= '0;
      por_n     <= 1'b0;
      srst_sync <= '0;
      RESOUT_N  <= 1'b0;
      strap_o   <= 5'b10000;
    end else begin
      if (por_count < POR_LAST) por_count <= por_count + 8'd1;
      if (por_count == POR_LAST) por_n <= 1'b1;
      srst_sync <= {srst_sync[0], SRSTn};
      RESOUT_N  <= !rst_req;
      if (!RESOUT_N) strap_o <= GPIO2[10:6];
    end
  end

  assign SRSTn = srst_drive ? 1'b0 : 1'bz;

  always_comb begin
    jtag_tck    = TCK;
    jtag_tms    = TMS;
    jtag_tdi    = TDI;
    jtag_trst_n = TRSTn;
    if (enable_cjtag) begin
      jtag_tck    = TCKC_pri;
      jtag_tms    = TMSC_pri;
      jtag_tdi    = 1'b1;
      jtag_trst_n = 1'b1;
    end
  end

  assign TDO          = (core_tdo_oe && !enable_cjtag) ? core_tdo : 1'bz;
  assign TMSC_pri     = (enable_cjtag && core_tmsc_oe) ? core_tmsc_o : 1'bz;
  assign TMSC_PUP_rep = enable_cjtag ? core_pup : 1'bz;
  assign TMSC_PDN_rep = enable_cjtag ? core_pdn : 1'bz;

  // GPIO2[10:6] carry the boot straps and are kept input-only.
  for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio
    assign GPIO0[i] = gpio0_oe[i] ? gpio0_o[i] : 1'bz;
    assign GPIO1[i] = gpio1_oe[i] ? gpio1_o[i] : 1'bz;
    if (i < 6 || i > 10) begin : g_gpio2_drv
      assign GPIO2[i] = gpio2_oe[i] ? gpio2_o[i] : 1'bz;
    end
  end

  assign unused_strap_drive = ^{gpio2_o[10:6], gpio2_oe[10:6]};

  assign gpio0_i = GPIO0;
  assign gpio1_i = GPIO1;
  assign gpio2_i = GPIO2;

  assign I2C0_SCL = i2c0_scl_oe ? 1'b0 : 1'bz;
  assign I2C0_SDA = i2c0_sda_oe ? 1'b0 : 1'bz;
  assign I2C1_SCL = i2c1_scl_oe ? 1'b0 : 1'bz;
  assign I2C1_SDA = i2c1_sda_oe ? 1'b0 : 1'bz;

  assign i2c0_scl_i = I2C0_SCL;
  assign i2c0_sda_i = I2C0_SDA;
  assign i2c1_scl_i = I2C1_SCL;
  assign i2c1_sda_i = I2C1_SDA;

  assign STBY_ACK_N = !core_stby_ack;
  assign I2C0_ENA   = 1'b1;
  assign I2C0_ADR   = 1'b0;

endmodule

// File: tb/tb_chip_top_wrapper.sv
// Directed bench for chip_top_wrapper: POR timing, strap latching, debug routing and pad control.
module tb_chip_top_wrapper;

  logic        tb_clk = 1'b0;
  logic        res_n;
  logic        core_srst_req, core_stby_ack;
  logic        trstn, tck, tms, tdi;
  logic        core_tdo, core_tdo_oe, core_tmsc_o, core_tmsc_oe, core_pup, core_pdn;
  logic [31:0] gpio0_o, gpio0_oe, gpio1_o, gpio1_oe, gpio2_o, gpio2_oe;
  logic [31:0] gpio0_i, gpio1_i, gpio2_i;
  logic        i2c0_scl_oe, i2c0_sda_oe, i2c1_scl_oe, i2c1_sda_oe;
  logic        i2c0_scl_i, i2c0_sda_i, i2c1_scl_i, i2c1_sda_i;
  logic        resout_n, stby_ack_n, i2c0_ena, i2c0_adr;
  logic [4:0]  strap_o;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
  logic        tckc_drv, tmsc_en, tmsc_drv, strap_en;
  logic [4:0]  strap_val;

  wire        srstn_pad, tdo_pad, tckc_pad, tmsc_pad, pup_pad, pdn_pad;
  wire        i2c0_scl_pad, i2c0_sda_pad, i2c1_scl_pad, i2c1_sda_pad;
  wire [31:0] gpio0_pad, gpio1_pad, gpio2_pad;

  pullup (srstn_pad);
  pullup (tdo_pad);
  pullup (tmsc_pad);
  pullup (pup_pad);
  pullup (pdn_pad);
  pullup (i2c0_scl_pad);
  pullup (i2c0_sda_pad);
  pullup (i2c1_scl_pad);
  pullup (i2c1_sda_pad);
  pullup (gpio0_pad);
  pullup (gpio1_pad);
  pullup (gpio2_pad);

  assign tckc_pad        = tckc_drv;
  assign tmsc_pad        = tmsc_en ? tmsc_drv : 1'bz;
  assign gpio2_pad[10:6] = strap_en ? strap_val : 5'bz;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #10 tb_clk = ~tb_clk;

  chip_top_wrapper #(.POR_CYCLES(16), .GPIO_W(32)) dut (
    .CLK50(tb_clk), .RES_N(res_n), .RESOUT_N(resout_n), .SRSTn(srstn_pad),
    .core_srst_req(core_srst_req), .STBY_ACK_N(stby_ack_n), .core_stby_ack(core_stby_ack),
    .strap_o(strap_o), .TRSTn(trstn), .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo_pad),
    .TCKC_pri(tckc_pad), .TMSC_pri(tmsc_pad), .TMSC_PUP_rep(pup_pad), .TMSC_PDN_rep(pdn_pad),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_trst_n(jtag_trst_n),
    .core_tdo(core_tdo), .core_tdo_oe(core_tdo_oe), .core_tmsc_o(core_tmsc_o),
    .core_tmsc_oe(core_tmsc_oe), .core_pup(core_pup), .core_pdn(core_pdn),
    .GPIO0(gpio0_pad), .GPIO1(gpio1_pad), .GPIO2(gpio2_pad),
    .gpio0_o(gpio0_o), .gpio0_oe(gpio0_oe), .gpio0_i(gpio0_i),
    .gpio1_o(gpio1_o), .gpio1_oe(gpio1_oe), .gpio1_i(gpio1_i),
    .gpio2_o(gpio2_o), .gpio2_oe(gpio2_oe), .gpio2_i(gpio2_i),
    .I2C0_SCL(i2c0_scl_pad), .I2C0_SDA(i2c0_sda_pad), .I2C1_SCL(i2c1_scl_pad), .I2C1_SDA(i2c1_sda_pad),
    .i2c0_scl_oe(i2c0_scl_oe), .i2c0_sda_oe(i2c0_sda_oe), .i2c1_scl_oe(i2c1_scl_oe), .i2c1_sda_oe(i2c1_sda_oe),
    .i2c0_scl_i(i2c0_scl_i), .i2c0_sda_i(i2c0_sda_i), .i2c1_scl_i(i2c1_scl_i), .i2c1_sda_i(i2c1_sda_i),
    .I2C0_ENA(i2c0_ena), .I2C0_ADR(i2c0_adr)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    strap_val = 5'b10001;
    repeat (3) tick();
    n_checks++; if (resout_n !== 1'b0) begin n_fail++; $display("FAIL reset_resout: got %b want 0", resout_n); end
    n_checks++; if (strap_o !== 5'b10000) begin n_fail++; $display("FAIL reset_strap: got %b want 10000", strap_o); end
    n_checks++; if (srstn_pad !== 1'b0) begin n_fail++; $display("FAIL reset_srstn: got %b want 0", srstn_pad); end
    n_checks++; if (dut.por_count !== 8'd0) begin n_fail++; $display("FAIL reset_por_count: got %0d want 0", dut.por_count); end
  endtask

  task automatic test_por_and_strap();
    res_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 16) begin
        n_checks++; if (dut.por_count !== 8'd16) begin n_fail++; $display("FAIL por_count16: got %0d want 16", dut.por_count); end
        n_checks++; if (dut.por_n !== 1'b0) begin n_fail++; $display("FAIL por_n_early: got %b want 0", dut.por_n); end
      end
      if (i == 17) begin
        n_checks++; if (dut.por_n !== 1'b1) begin n_fail++; $display("FAIL por_n_set: got %b want 1", dut.por_n); end
      end
      if (i == 19) begin
        n_checks++; if (resout_n !== 1'b0) begin n_fail++; $display("FAIL resout_early: got %b want 0", resout_n); end
      end
    end
    n_checks++; if (resout_n !== 1'b1) begin n_fail++; $display("FAIL resout_release: got %b want 1", resout_n); end
    strap_val = 5'b00000;
    repeat (3) tick();
    n_checks++; if (strap_o !== 5'b10001) begin n_fail++; $display("FAIL strap_frozen: got %b want 10001", strap_o); end
    n_checks++; if (dut.por_count !== 8'd16) begin n_fail++; $display("FAIL por_count_hold: got %0d want 16", dut.por_count); end
  endtask

  task automatic test_cjtag();
    tckc_drv = 1'b1; tmsc_en = 1'b1; tmsc_drv = 1'b0; core_tmsc_oe = 1'b0;
    tck = 1'b0; tms = 1'b1; tdi = 1'b0; trstn = 1'b0;
    core_tdo_oe = 1'b1; core_tdo = 1'b0; core_pup = 1'b0; core_pdn = 1'b1;
    #1;
    n_checks++; if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n} !== 4'b1011) begin n_fail++; $display("FAIL cjtag_mux_a: got %b want 1011", {jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n}); end
    tckc_drv = 1'b0; tmsc_drv = 1'b1;
    #1;
    n_checks++; if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n} !== 4'b0111) begin n_fail++; $display("FAIL cjtag_mux_b: got %b want 0111", {jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n}); end
    n_checks++; if (tdo_pad !== 1'b1) begin n_fail++; $display("FAIL cjtag_tdo_z: got %b want 1", tdo_pad); end
    n_checks++; if ({pup_pad, pdn_pad} !== 2'b01) begin n_fail++; $display("FAIL cjtag_keeper: got %b want 01", {pup_pad, pdn_pad}); end
    tmsc_en = 1'b0; core_tmsc_oe = 1'b1; core_tmsc_o = 1'b0;
    #1;
    n_checks++; if (tmsc_pad !== 1'b0) begin n_fail++; $display("FAIL cjtag_tmsc_drive: got %b want 0", tmsc_pad); end
    core_tmsc_oe = 1'b0;
    #1;
    n_checks++; if (tmsc_pad !== 1'b1) begin n_fail++; $display("FAIL cjtag_tmsc_release: got %b want 1", tmsc_pad); end
  endtask

  task automatic test_srst_request();
    strap_val = 5'b10000;
    core_srst_req = 1'b1;
    #1;
    n_checks++; if (srstn_pad !== 1'b0) begin n_fail++; $display("FAIL srst_pin_low: got %b want 0", srstn_pad); end
    tick();
    core_srst_req = 1'b0;
    tick();
    n_checks++; if (resout_n !== 1'b1) begin n_fail++; $display("FAIL srst_resout_sync: got %b want 1", resout_n); end
    tick();
    n_checks++; if (resout_n !== 1'b0) begin n_fail++; $display("FAIL srst_resout_assert: got %b want 0", resout_n); end
    n_checks++; if (srstn_pad !== 1'b1) begin n_fail++; $display("FAIL srst_pin_release: got %b want 1", srstn_pad); end
    tick();
    n_checks++; if (resout_n !== 1'b1) begin n_fail++; $display("FAIL srst_resout_recover: got %b want 1", resout_n); end
    n_checks++; if (strap_o !== 5'b10000) begin n_fail++; $display("FAIL srst_strap_recapture: got %b want 10000", strap_o); end
    n_checks++; if (dut.por_count !== 8'd16) begin n_fail++; $display("FAIL srst_por_count: got %0d want 16", dut.por_count); end
  endtask

  task automatic test_jtag();
    tck = 1'b1; tms = 1'b0; tdi = 1'b1; trstn = 1'b0; tckc_drv = 1'b0;
    core_tdo_oe = 1'b1; core_tdo = 1'b1; core_pup = 1'b0; core_pdn = 1'b0;
    core_tmsc_oe = 1'b1; core_tmsc_o = 1'b0;
    #1;
    n_checks++; if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n} !== 4'b1010) begin n_fail++; $display("FAIL jtag_mux: got %b want 1010", {jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n}); end
    n_checks++; if (tdo_pad !== 1'b1) begin n_fail++; $display("FAIL jtag_tdo_1: got %b want 1", tdo_pad); end
    n_checks++; if ({tmsc_pad, pup_pad, pdn_pad} !== 3'b111) begin n_fail++; $display("FAIL jtag_cjtag_pins_z: got %b want 111", {tmsc_pad, pup_pad, pdn_pad}); end
    core_tdo = 1'b0;
    #1;
    n_checks++; if (tdo_pad !== 1'b0) begin n_fail++; $display("FAIL jtag_tdo_0: got %b want 0", tdo_pad); end
    core_tdo_oe = 1'b0;
    #1;
    n_checks++; if (tdo_pad !== 1'b1) begin n_fail++; $display("FAIL jtag_tdo_z: got %b want 1", tdo_pad); end
  endtask

  task automatic test_i2c_misc();
    i2c0_sda_oe = 1'b1; i2c1_scl_oe = 1'b1; core_stby_ack = 1'b1;
    #1;
    n_checks++; if ({i2c0_sda_pad, i2c0_sda_i} !== 2'b00) begin n_fail++; $display("FAIL i2c0_sda_low: got %b want 00", {i2c0_sda_pad, i2c0_sda_i}); end
    n_checks++; if ({i2c0_scl_i, i2c1_scl_i, i2c1_sda_i} !== 3'b101) begin n_fail++; $display("FAIL i2c_others_a: got %b want 101", {i2c0_scl_i, i2c1_scl_i, i2c1_sda_i}); end
    n_checks++; if ({stby_ack_n, i2c0_ena, i2c0_adr} !== 3'b010) begin n_fail++; $display("FAIL stby_ena_adr: got %b want 010", {stby_ack_n, i2c0_ena, i2c0_adr}); end
    i2c0_sda_oe = 1'b0; i2c1_scl_oe = 1'b0; i2c0_scl_oe = 1'b1; core_stby_ack = 1'b0;
    #1;
    n_checks++; if ({i2c0_sda_pad, i2c0_sda_i} !== 2'b11) begin n_fail++; $display("FAIL i2c0_sda_release: got %b want 11", {i2c0_sda_pad, i2c0_sda_i}); end
    n_checks++; if ({i2c0_scl_pad, i2c0_scl_i, i2c1_scl_i, stby_ack_n} !== 4'b0011) begin n_fail++; $display("FAIL i2c_others_b: got %b want 0011", {i2c0_scl_pad, i2c0_scl_i, i2c1_scl_i, stby_ack_n}); end
    i2c0_scl_oe = 1'b0;
  endtask

  task automatic test_gpio();
    gpio0_oe = 32'h0000_FFFF; gpio0_o = 32'h1234_5678;
    gpio1_oe = 32'hFF00_0000; gpio1_o = 32'h0000_0000;
    gpio2_oe = 32'hFFFF_FFFF; gpio2_o = 32'h0000_0000;
    strap_val = 5'b10101;
    #1;
    n_checks++; if (gpio0_pad !== 32'hFFFF_5678) begin n_fail++; $display("FAIL gpio0_pad: got %h want ffff5678", gpio0_pad); end
    n_checks++; if (gpio0_i !== 32'hFFFF_5678) begin n_fail++; $display("FAIL gpio0_in: got %h want ffff5678", gpio0_i); end
    n_checks++; if (gpio1_i !== 32'h00FF_FFFF) begin n_fail++; $display("FAIL gpio1_in: got %h want 00ffffff", gpio1_i); end
    n_checks++; if (gpio2_i !== 32'h0000_0540) begin n_fail++; $display("FAIL gpio2_strap_bits_undriven: got %h want 00000540", gpio2_i); end
    gpio2_o = 32'hFFFF_FFFF; strap_val = 5'b00000;
    #1;
    n_checks++; if (gpio2_i !== 32'hFFFF_F83F) begin n_fail++; $display("FAIL gpio2_drive_high: got %h want fffff83f", gpio2_i); end
    tick();
    n_checks++; if (strap_o !== 5'b10000) begin n_fail++; $display("FAIL strap_hold_after_gpio: got %b want 10000", strap_o); end
  endtask

  initial begin
    res_n = 1'b0; core_srst_req = 1'b0; core_stby_ack = 1'b0;
    trstn = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    core_tdo = 1'b0; core_tdo_oe = 1'b0; core_tmsc_o = 1'b0; core_tmsc_oe = 1'b0;
    core_pup = 1'b0; core_pdn = 1'b0;
    gpio0_o = '0; gpio0_oe = '0; gpio1_o = '0; gpio1_oe = '0; gpio2_o = '0; gpio2_oe = '0;
    i2c0_scl_oe = 1'b0; i2c0_sda_oe = 1'b0; i2c1_scl_oe = 1'b0; i2c1_sda_oe = 1'b0;
    tckc_drv = 1'b0; tmsc_en = 1'b0; tmsc_drv = 1'b0; strap_en = 1'b1; strap_val = 5'b10001;

    test_reset();
    test_por_and_strap();
    test_cjtag();
    test_srst_request();
    test_jtag();
    test_i2c_misc();
    test_gpio();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
